// File: rtl/mant_mul_seq.sv
// Sequential shift-add mantissa multiplier.
// Normalizes and rounds the product to nearest-even.
module mant_mul_seq #(
  parameter int size = 24
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [size-1:0] a,
  input  logic [size-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [size-1:0] out,
  output logic            exp_inc
);

  localparam int w  = 2 * size;
  localparam int cw = (size > 1) ? $clog2(size) : 1;

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    NORM,
    DONE
  } state_t;

  state_t state;
  state_t nxt;

  logic [size-1:0] a_r;
  logic [size-1:0] b_r;
  logic [w-1:0]    acc;
  logic [cw-1:0]   cnt;
  logic            last;
  logic [w-1:0]    addend;

  logic [size-1:0] m;
  logic            g;
  logic            s;
  logic            e;
  logic            inc;
  logic [size:0]   sum;
  logic [size-1:0] rm;
  logic            re;

  assign last   = (cnt == cw'(size - 1));
  assign addend = {{size{1'b0}}, a_r} << cnt;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:    if (start) nxt = MUL;
      DONE:    if (start) nxt = MUL;
      MUL:     if (last)  nxt = NORM;
      NORM:    nxt = DONE;
      default: nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == MUL) || (state == NORM);
  end

  // Product is either [1,2) or [2,4) in fixed point; pick the window.
  always_comb begin
    if (acc[w-1]) begin
      m = acc[w-1:size];
      g = acc[size-1];
      s = |acc[size-2:0];
      e = 1'b1;
    end else begin
      m = acc[w-2:size-1];
      g = acc[size-2];
      s = |acc[size-3:0];
      e = 1'b0;
    end
    inc = g & (s | m[0]);
    sum = {1'b0, m} + {{size{1'b0}}, inc};
    if (sum[size]) begin
      rm = {1'b1, {(size-1){1'b0}}};
      re = 1'b1;
    end else begin
      rm = sum[size-1:0];
      re = e;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_r     <= '0;
      b_r     <= '0;
      acc     <= '0;
      cnt     <= '0;
      out     <= '0;
      exp_inc <= 1'b0;
      done    <= 1'b0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            a_r     <= a;
            b_r     <= b;
            acc     <= '0;
            cnt     <= '0;
            out     <= '0;
            exp_inc <= 1'b0;
            done    <= 1'b0;
          end
        end
        MUL: begin
          if (b_r[cnt]) acc <= acc + addend;
          if (!last)    cnt <= cnt + 1'b1;
        end
        NORM: begin
          out     <= rm;
          exp_inc <= re;
          done    <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mant_mul_seq.sv
// Self-checking bench for mant_mul_seq.
// Arithmetic reference model plus directed literal vectors.
module tb_mant_mul_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [23:0] a = '0;
  logic [23:0] b = '0;
  logic        busy;
  logic        done;
  logic [23:0] out;
  logic        exp_inc;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  mant_mul_seq #(.size(24)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .a(a),
    .b(b),
    .busy(busy),
    .done(done),
    .out(out),
    .exp_inc(exp_inc)
  );

  always #5 clk = ~clk;

  function automatic logic [24:0] ref_mul(input logic [23:0] x,
                                          input logic [23:0] y);
    logic [63:0] p, m, rem, half;
    int sh;
    logic ex;
    p = 64'(x) * 64'(y);
    if (p >= 64'h8000_0000_0000) begin
      sh = 24; ex = 1'b1;
    end else begin
      sh = 23; ex = 1'b0;
    end
    m    = p >> sh;
    rem  = p - (m << sh);
    half = 64'd1 << (sh - 1);
    if (rem > half || (rem == half && m[0])) m = m + 1;
    if (m == 64'h100_0000) begin
      m  = 64'h80_0000;
      ex = 1'b1;
    end
    return {ex, m[23:0]};
  endfunction

  logic [23:0] qa, qb;
  logic        mbusy = 1'b0;
  logic        mdone = 1'b0;
  logic [23:0] mout = '0;
  logic        me = 1'b0;
  int          k = 0;

  always @(posedge clk) begin
    if (rst) begin
      mbusy = 1'b0; mdone = 1'b0;
      mout = '0; me = 1'b0; k = 0;
    end else if (!mbusy && start) begin
      qa = a; qb = b;
      mbusy = 1'b1; mdone = 1'b0;
      mout = '0; me = 1'b0; k = 0;
    end else if (mbusy) begin
      k++;
      if (k == 25) begin
        mbusy = 1'b0;
        mdone = 1'b1;
        {me, mout} = ref_mul(qa, qb);
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      checks++;
      if (busy !== mbusy || done !== mdone ||
          out !== mout || exp_inc !== me) begin
        errors++;
        $display("FAIL cycle t=%0t busy=%b/%b done=%b/%b out=%h/%h exp_inc=%b/%b",
                 $time, busy, mbusy, done, mdone, out, mout, exp_inc, me);
      end
    end
  end

  task automatic check(input string nm, input logic [31:0] got,
                       input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h want=%h", nm, got, want);
    end
  endtask

  task automatic do_start(input logic [23:0] x, input logic [23:0] y);
    @(negedge clk);
    a = x; b = y; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = 24'($urandom); b = 24'($urandom);
  endtask

  task automatic wait_done();
    int i;
    for (i = 0; i < 60 && !done; i++) @(negedge clk);
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL timeout got=done0 want=done1");
    end
  endtask

  task automatic directed(input string nm, input logic [23:0] x,
                          input logic [23:0] y, input logic [23:0] wo,
                          input logic we);
    int bc;
    do_start(x, y);
    bc = 0;
    for (int i = 0; i < 60 && !done; i++) begin
      if (busy) bc++;
      @(negedge clk);
    end
    check({nm, "_done"}, 32'(done), 32'd1);
    check({nm, "_busy_cycles"}, bc, 25);
    check({nm, "_out"}, 32'(out), 32'(wo));
    check({nm, "_exp"}, 32'(exp_inc), 32'(we));
  endtask

  initial begin
    logic [24:0] r;
    r = ref_mul(24'hC00000, 24'hC00000);
    check("model_c0", 32'(r), 32'h1900000);
    r = ref_mul(24'h800001, 24'hC00000);
    check("model_tie", 32'(r), 32'h0C00002);
    r = ref_mul(24'hFFFFFF, 24'hFFFFFF);
    check("model_ff", 32'(r), 32'h1FFFFFE);

    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_out", 32'(out), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    cmp_en = 1'b1;

    directed("one", 24'h800000, 24'h800000, 24'h800000, 1'b0);
    directed("c0", 24'hC00000, 24'hC00000, 24'h900000, 1'b1);
    directed("tie", 24'h800001, 24'hC00000, 24'hC00002, 1'b0);
    directed("ff", 24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFE, 1'b1);
    directed("rdn", 24'h800001, 24'h800001, 24'h800002, 1'b0);

    // restart ignored while busy
    do_start(24'hC00000, 24'hC00000);
    repeat (8) @(negedge clk);
    do_start(24'hFFFFFF, 24'h800001);
    wait_done();
    check("ign_out", 32'(out), 32'h900000);
    check("ign_exp", 32'(exp_inc), 32'd1);

    // start in DONE with zero operand
    do_start(24'h000000, 24'h800000);
    check("drop_done", 32'(done), 32'd0);
    wait_done();
    check("zero_out", 32'(out), 32'd0);
    check("zero_exp", 32'(exp_inc), 32'd0);

    // reset mid-operation
    do_start(24'hABCDEF, 24'hFEDCBA);
    repeat (13) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mrst_busy", 32'(busy), 32'd0);
    check("mrst_out", 32'(out), 32'd0);
    begin
      int seen = 0;
      repeat (40) begin
        @(negedge clk);
        if (done) seen++;
      end
      check("mrst_nodone", seen, 0);
    end

    for (int n = 0; n < 40; n++) begin
      logic [23:0] x, y;
      x = 24'($urandom) | 24'h800000;
      y = 24'($urandom) | 24'h800000;
      if ($urandom_range(0, 7) == 0) x = '0;
      if ($urandom_range(0, 7) == 0) y = '0;
      do_start(x, y);
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(0, 20)) @(negedge clk);
        do_start(24'($urandom), 24'($urandom));
      end
      if ($urandom_range(0, 9) == 0) begin
        repeat ($urandom_range(0, 24)) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
      end else begin
        wait_done();
        repeat ($urandom_range(0, 3)) @(negedge clk);
      end
    end

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
